// File: rtl/timer_seq_pkg.sv
// Shared definitions for the JK interval-timer sequencer.
package timer_seq_pkg;

  // FSM state encodings (2-bit, kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Per-cycle command from the FSM to the counter datapath
  typedef struct packed {
    logic load;  // parallel-load preset this edge
    logic en;    // increment this edge
  } cnt_ctl_t;

endpackage

// File: rtl/jk_timer_sequencer_if.sv
// Host-side control/status bundle for the timer sequencer.
interface jk_timer_sequencer_if #(parameter int WIDTH = 4);
  logic             start;
  logic             stop;
  logic             one_shot;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tick;
  logic             done;

  // Host drives control, observes status
  modport master (output start, stop, one_shot, preset,
                  input  count, busy, tick, done);

  // Timer consumes control, drives status
  modport slave  (input  start, stop, one_shot, preset,
                  output count, busy, tick, done);
endinterface

// File: rtl/jk_flip_flop.sv
// Positive-edge JK flip-flop with synchronous active-low clear.
module jk_flip_flop (
  input  logic clk,
  input  logic clr_n_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  // Classic JK behaviour: hold / reset / set / toggle; clear dominates
  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      q_q <= 1'b0;
    end else begin
      case ({j_i, k_i})
        2'b00:   q_q <= q_q;
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        default: q_q <= ~q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_load_counter.sv
// Loadable synchronous up-counter built from JK cells.
// Load forces each cell to its data bit (J=d, K=~d); counting toggles a
// cell when every lower bit is 1 (ripple-free carry on the J/K inputs).
module jk_load_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_bar,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;

  // Toggle enables: bit i flips when enabled and all lower bits are 1
  assign t[0] = en;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign t[i] = t[i-1] & q[i-1];
  end

  // J/K muxing: load wins, otherwise toggle-or-hold (J=K=t)
  for (genvar i = 0; i < WIDTH; i++) begin : g_jk
    assign j[i] = load ? d[i]  : t[i];
    assign k[i] = load ? ~d[i] : t[i];
  end

  jk_flip_flop u_ff [WIDTH-1:0] (
    .clk     (clk),
    .clr_n_i (clr_bar),
    .j_i     (j),
    .k_i     (k),
    .q_o     (q)
  );

endmodule

// File: rtl/jk_timer_sequencer.sv
// Programmable interval timer: loads a preset, counts to all-ones, then
// stops (one-shot) or reloads (periodic). FSM + status decode around a
// JK-based load counter.
module jk_timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  jk_timer_sequencer_if.slave  bus
);

  logic [1:0]       state_q, state_d;
  logic             latch_q, latch_d;   // one_shot captured at start
  cnt_ctl_t         ctl;
  logic [WIDTH-1:0] count;
  logic             term;

  assign term = &count;

  // Next-state and counter command; stop in RUN beats terminal count
  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    ctl     = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          latch_d = bus.one_shot;
        end
      end
      ST_LOAD: begin
        ctl.load = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (term) begin
          if (latch_q) state_d  = ST_DONE;
          else         ctl.load = 1'b1;
        end else begin
          ctl.en = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and one-shot latch registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
    end
  end

  jk_load_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .clr_bar (~clr),
    .load    (ctl.load),
    .en      (ctl.en),
    .d       (bus.preset),
    .q       (count)
  );

  // Status decode purely from registered state/count
  assign bus.count = count;
  assign bus.busy  = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign bus.tick  = (state_q == ST_RUN) && term;
  assign bus.done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_jk_timer_sequencer.sv
// Self-checking bench for jk_timer_sequencer (WIDTH=4).
module tb_jk_timer_sequencer;

  logic clk = 1'b0;
  logic clr;

  jk_timer_sequencer_if #(.WIDTH(4)) bus ();

  jk_timer_sequencer #(.WIDTH(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, start, stop, one_shot;
    logic [3:0] preset;
    logic [3:0] cnt;
    logic       busy, tick, done;
  } vec_t;

  typedef struct {
    logic [6:0] exp;
    int         id;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   vid      = 0;

  function automatic vec_t mk(input logic c, s, p, o, input logic [3:0] pr,
                              input logic [3:0] n, input logic b, t, d);
    vec_t v;
    v.clr = c; v.start = s; v.stop = p; v.one_shot = o; v.preset = pr;
    v.cnt = n; v.busy = b; v.tick = t; v.done = d;
    return v;
  endfunction

  // Drive one cycle of inputs (at negedge) and queue what must appear after the edge
  task automatic step(input vec_t v);
    sb_t e;
    clr          = v.clr;
    bus.start    = v.start;
    bus.stop     = v.stop;
    bus.one_shot = v.one_shot;
    bus.preset   = v.preset;
    e.exp = {v.cnt, v.busy, v.tick, v.done};
    e.id  = vid;
    vid++;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: compare just after each active edge
  always @(posedge clk) begin : mon
    sb_t        e;
    logic [6:0] got;
    #1;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      got = {bus.count, bus.busy, bus.tick, bus.done};
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL vec%0d count/busy/tick/done got=%0d/%b/%b/%b exp=%0d/%b/%b/%b",
                 e.id, got[6:3], got[2], got[1], got[0],
                 e.exp[6:3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  end

  initial begin
    clr = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
    bus.one_shot = 1'b0; bus.preset = 4'd0;
    @(negedge clk);

    //              clr st sp os pre  cnt bsy tck dn
    // reset
    tbl.push_back(mk(1, 0, 0, 0, 4'd0,  4'd0,  0, 0, 0));
    // one-shot, preset 12
    tbl.push_back(mk(0, 1, 0, 1, 4'd12, 4'd0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd12, 4'd12, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd12, 4'd13, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd12, 4'd14, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd12, 4'd15, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd12, 4'd15, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'd12, 4'd15, 0, 0, 0));
    // periodic, preset 14: tick every other cycle, never done
    tbl.push_back(mk(0, 1, 0, 0, 4'd14, 4'd15, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd14, 4'd14, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd14, 4'd15, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd14, 4'd14, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd14, 4'd15, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd14, 4'd14, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd14, 4'd14, 0, 0, 0));
    // periodic preset 3, stop at count 9
    tbl.push_back(mk(0, 1, 0, 0, 4'd3,  4'd14, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd3,  4'd3,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd3,  4'd4,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd3,  4'd5,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd3,  4'd6,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd3,  4'd7,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd3,  4'd8,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd3,  4'd9,  1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd3,  4'd9,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd3,  4'd9,  0, 0, 0));
    // clr mid-run at count 7, then a normal one-shot run
    tbl.push_back(mk(0, 1, 0, 0, 4'd5,  4'd9,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd5,  4'd5,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd5,  4'd6,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd5,  4'd7,  1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'd5,  4'd0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 4'd13, 4'd0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd13, 4'd13, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd13, 4'd14, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd13, 4'd15, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd13, 4'd15, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'd13, 4'd15, 0, 0, 0));
    // preset all-ones periodic: tick every RUN cycle; stop coincident with tick
    tbl.push_back(mk(0, 1, 0, 0, 4'd15, 4'd15, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd15, 4'd15, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd15, 4'd15, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd15, 4'd15, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd15, 4'd15, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd15, 4'd15, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Hand sequence: start re-pulsed mid-run, preset 5 -> 9 only at reload
    step(mk(0, 1, 0, 0, 4'd5, 4'd15, 1, 0, 0));
    step(mk(0, 0, 0, 0, 4'd5, 4'd5,  1, 0, 0));
    step(mk(0, 1, 0, 0, 4'd9, 4'd6,  1, 0, 0));
    for (int n = 7; n <= 14; n++)
      step(mk(0, (n == 11), 0, 1, 4'd9, 4'(n), 1, 0, 0));
    step(mk(0, 0, 0, 0, 4'd9, 4'd15, 1, 1, 0));
    step(mk(0, 0, 0, 0, 4'd9, 4'd9,  1, 0, 0));
    step(mk(0, 0, 0, 0, 4'd9, 4'd10, 1, 0, 0));
    step(mk(0, 0, 1, 0, 4'd9, 4'd10, 0, 0, 0));

    // Hand sequence: start during DONE is dropped, not queued
    step(mk(0, 1, 0, 1, 4'd14, 4'd10, 1, 0, 0));
    step(mk(0, 0, 0, 0, 4'd14, 4'd14, 1, 0, 0));
    step(mk(0, 0, 0, 0, 4'd14, 4'd15, 1, 1, 0));
    step(mk(0, 0, 0, 0, 4'd14, 4'd15, 0, 0, 1));
    step(mk(0, 1, 0, 0, 4'd14, 4'd15, 0, 0, 0));
    step(mk(0, 0, 0, 0, 4'd14, 4'd15, 0, 0, 0));

    // Bounded drain of the scoreboard
    for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
